// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader writing 32-bit words into CPU IMEM
// Optional feature macro: IMEM_LOADER_CSUM_EN (trailing XOR checksum byte after the data)
module imem_loader #(
  parameter int IMEM_WORDS = 64,
  parameter int ADDR_W     = $clog2(IMEM_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  input  logic              cpu_halt,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [ADDR_W:0]   WL_ONE  = 1;
  localparam logic [ADDR_W-1:0] IDX_ONE = 1;

  state_t            state;
  logic [7:0]        len_lo;
  logic [ADDR_W-1:0] widx;
  logic [ADDR_W-1:0] last_idx;
  logic [1:0]        bidx;
  logic [23:0]       asm_buf;
  logic              fin;
  logic              acc;
  logic [15:0]       len_n;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum;
`endif

  // a byte moves only when both sides agree; s_ready is registered so it is the sole throttle
  assign acc   = s_valid & s_ready;
  assign len_n = {s_data, len_lo};

  // loader FSM: all outputs registered, write issued the cycle after a word's 4th byte
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_LEN_LO;
      s_ready      <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_reset    <= 1'b1;
      load_err     <= 1'b0;
      words_loaded <= '0;
      len_lo       <= '0;
      widx         <= '0;
      last_idx     <= '0;
      bidx         <= '0;
      asm_buf      <= '0;
      fin          <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum         <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_LEN_LO: begin
          cpu_reset <= 1'b1;
          s_ready   <= 1'b1;
          if (acc) begin
            len_lo <= s_data;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (acc) begin
            words_loaded <= '0;
            if (len_n == 16'd0 || len_n > 16'(IMEM_WORDS)) begin
              state    <= S_ERR;
              s_ready  <= 1'b0;
              load_err <= 1'b1;
            end else begin
              state    <= S_DATA;
              last_idx <= ADDR_W'(len_n - 16'd1);
              widx     <= '0;
              bidx     <= '0;
`ifdef IMEM_LOADER_CSUM_EN
              csum     <= '0;
`endif
            end
          end
        end
        S_DATA: begin
          if (acc) begin
`ifdef IMEM_LOADER_CSUM_EN
            csum <= csum ^ s_data;
`endif
            bidx <= bidx + 2'd1;
            case (bidx)
              2'd0: asm_buf[7:0]   <= s_data;
              2'd1: asm_buf[15:8]  <= s_data;
              2'd2: asm_buf[23:16] <= s_data;
              default: begin
                imem_we      <= 1'b1;
                imem_addr    <= widx;
                imem_wdata   <= {s_data, asm_buf};
                widx         <= widx + IDX_ONE;
                words_loaded <= words_loaded + WL_ONE;
                if (widx == last_idx) begin
`ifdef IMEM_LOADER_CSUM_EN
                  state <= S_CSUM;
`else
                  // stop taking bytes; release the CPU once the final write has gone out
                  s_ready <= 1'b0;
                  fin     <= 1'b1;
`endif
                end
              end
            endcase
          end else if (fin) begin
            fin       <= 1'b0;
            state     <= S_RUN;
            cpu_reset <= 1'b0;
          end
        end
`ifdef IMEM_LOADER_CSUM_EN
        S_CSUM: begin
          if (acc) begin
            s_ready <= 1'b0;
            if ((csum ^ s_data) == 8'd0) begin
              state     <= S_RUN;
              cpu_reset <= 1'b0;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
        end
`endif
        S_RUN: begin
          if (cpu_halt) begin
            cpu_reset <= 1'b1;
            s_ready   <= 1'b1;
            state     <= S_LEN_LO;
          end
        end
        S_ERR: begin
          cpu_reset <= 1'b1;
          s_ready   <= 1'b0;
          load_err  <= 1'b1;
        end
        default: begin
          state     <= S_ERR;
          cpu_reset <= 1'b1;
          s_ready   <= 1'b0;
          load_err  <= 1'b1;
        end
      endcase
    end
  end

endmodule
